fta_copy_initiator: RTL and testbench

//  Bus-master (initiator) block copy engine on the fta 128-bit bus: reads len_i beats from src_i, writes them to dst_i.

---
 rtl/fta_bus_pkg.sv | 9 +
 rtl/fta_copy_pkg.sv | 17 +
 rtl/fta_copy_buf.sv | 22 ++
 rtl/fta_copy_initiator.sv | 206 ++++++++++++++++++++
 tb/tb_fta_copy_initiator.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fta_bus_pkg.sv
// Shared fta bus types: transaction id and cycle-type codes used by every fta master/responder.
package fta_bus_pkg;

  typedef logic [7:0] fta_tranid_t;

  localparam logic [2:0] CLASSIC = 3'b000;
  localparam logic [2:0] ERC     = 3'b001;

endpackage

// File: rtl/fta_copy_pkg.sv
// Types and sizing constants for the fta block copy initiator.
package fta_copy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_WR_ISSUE,
    ST_WR_WAIT,
    ST_FINISH
  } copy_state_t;

  localparam int DEF_CHUNK    = 16;
  localparam int CHUNK_BITS   = $clog2(DEF_CHUNK);
  localparam int TIMEOUT_BITS = 10;

endpackage

// File: rtl/fta_copy_buf.sv
// Chunk staging buffer: synchronous write by beat index, asynchronous read by beat index.
module fta_copy_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [127:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [127:0]  rdata
);

  logic [127:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fta_copy_initiator.sv
// fta bus-master block copy engine: chunked read-all / write-all loop with ack timeout.
// Build option FTA_COPY_CSUM_EN adds a running XOR checksum of copied beats on csum_o.
//
// state     | meaning
// IDLE      | waiting for start_i
// RD_ISSUE  | one read request per cycle for the current chunk
// RD_WAIT   | collecting remaining read acks into the buffer
// WR_ISSUE  | one ERC write per cycle from the buffer
// WR_WAIT   | collecting write acks, then advance addresses
// FINISH    | pulse done_o, drop busy_o
module fta_copy_initiator
  import fta_bus_pkg::*;
  import fta_copy_pkg::*;
#(
  parameter int         CHUNK   = DEF_CHUNK,
  parameter logic [3:0] CID     = 4'd5,
  parameter int         TIMEOUT = 1023
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [31:0]          src_i,
  input  logic [31:0]          dst_i,
  input  logic [15:0]          len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [127:0]         csum_o,
  output logic                 cyc_o,
  output logic                 stb_o,
  output logic                 we_o,
  output logic [2:0]           cti_o,
  output logic [5:0]           blen_o,
  output logic [15:0]          sel_o,
  output logic [31:0]          adr_o,
  output logic [127:0]         dat_o,
  output fta_tranid_t          tid_o,
  output logic [3:0]           cid_o,
  input  logic                 ack_i,
  input  logic [3:0]           cid_i,
  input  fta_tranid_t          tid_i,
  input  logic [127:0]         dat_i
);

  localparam int CB = $clog2(CHUNK);
  localparam int CW = CB + 1;

  copy_state_t             state;
  logic [31:0]             src_q, dst_q;
  logic [15:0]             rem_q;
  logic [CB-1:0]           idx_q;
  logic [CW-1:0]           ack_cnt_q;
  logic [TIMEOUT_BITS-1:0] tmo_q;

  logic [CW-1:0] n_beats, ack_cnt_nx;
  logic          rd_phase, wr_phase, rd_ack, wr_ack, phase_done, last_issue, start_ok;
  logic          tmo_hit;
  logic [127:0]  buf_rd;
  logic          unused_ok;

  always_comb begin
    n_beats    = (rem_q >= 16'(CHUNK)) ? CW'(CHUNK) : CW'(rem_q);
    rd_phase   = (state == ST_RD_ISSUE) || (state == ST_RD_WAIT);
    wr_phase   = (state == ST_WR_ISSUE) || (state == ST_WR_WAIT);
    rd_ack     = ack_i && (cid_i == CID) && rd_phase;
    wr_ack     = ack_i && (cid_i == CID) && wr_phase;
    ack_cnt_nx = ack_cnt_q + CW'(rd_ack | wr_ack);
    phase_done = (ack_cnt_nx == n_beats);
    last_issue = (CW'(idx_q) == n_beats - CW'(1));
    start_ok   = start_i && !busy_o;
    tmo_hit    = (tmo_q == TIMEOUT_BITS'(TIMEOUT - 1));
  end

  fta_copy_buf #(.DEPTH(CHUNK), .AW(CB)) u_buf (
    .clk_i (clk_i),
    .we    (rd_ack),
    .waddr (tid_i[CB-1:0]),
    .wdata (dat_i),
    .raddr (idx_q),
    .rdata (buf_rd)
  );

  assign blen_o    = '0;
  assign cid_o     = CID;
  assign unused_ok = ^{src_i[3:0], dst_i[3:0], tid_i[$bits(fta_tranid_t)-1:CB]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      ack_cnt_q <= '0;
      tmo_q     <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      cyc_o     <= 1'b0;
      stb_o     <= 1'b0;
      we_o      <= 1'b0;
      cti_o     <= '0;
      sel_o     <= '0;
      adr_o     <= '0;
      dat_o     <= '0;
      tid_o     <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            err_o <= 1'b0;
            if (len_i == 16'd0) begin
              done_o <= 1'b1;
            end else begin
              src_q     <= {src_i[31:4], 4'h0};
              dst_q     <= {dst_i[31:4], 4'h0};
              rem_q     <= len_i;
              idx_q     <= '0;
              ack_cnt_q <= '0;
              tmo_q     <= '0;
              busy_o    <= 1'b1;
              state     <= ST_RD_ISSUE;
            end
          end
        end
        ST_RD_ISSUE, ST_WR_ISSUE: begin
          cyc_o     <= 1'b1;
          stb_o     <= 1'b1;
          sel_o     <= 16'hFFFF;
          tid_o     <= fta_tranid_t'(idx_q);
          tmo_q     <= '0;
          ack_cnt_q <= ack_cnt_nx;
          if (state == ST_RD_ISSUE) begin
            we_o  <= 1'b0;
            cti_o <= CLASSIC;
            adr_o <= src_q + (32'(idx_q) << 4);
            dat_o <= '0;
          end else begin
            we_o  <= 1'b1;
            cti_o <= ERC;
            adr_o <= dst_q + (32'(idx_q) << 4);
            dat_o <= buf_rd;
          end
          if (last_issue) begin
            idx_q <= '0;
            state <= (state == ST_RD_ISSUE) ? ST_RD_WAIT : ST_WR_WAIT;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_RD_WAIT, ST_WR_WAIT: begin
          stb_o     <= 1'b0;
          sel_o     <= '0;
          ack_cnt_q <= ack_cnt_nx;
          if (phase_done) begin
            // cyc_o low for one cycle marks the phase boundary
            cyc_o     <= 1'b0;
            ack_cnt_q <= '0;
            tmo_q     <= '0;
            if (state == ST_RD_WAIT) begin
              state <= ST_WR_ISSUE;
            end else begin
              src_q <= src_q + (32'(n_beats) << 4);
              dst_q <= dst_q + (32'(n_beats) << 4);
              rem_q <= rem_q - 16'(n_beats);
              state <= (rem_q == 16'(n_beats)) ? ST_FINISH : ST_RD_ISSUE;
            end
          end else if (rd_ack || wr_ack) begin
            tmo_q <= '0;
          end else if (tmo_hit) begin
            err_o <= 1'b1;
            cyc_o <= 1'b0;
            state <= ST_FINISH;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_FINISH: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          cyc_o  <= 1'b0;
          stb_o  <= 1'b0;
          sel_o  <= '0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FTA_COPY_CSUM_EN
  logic [127:0] csum_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                              csum_q <= '0;
    else if (state == ST_IDLE && start_ok)  csum_q <= '0;
    else if (rd_ack)                        csum_q <= csum_q ^ dat_i;
  end

  assign csum_o = csum_q;
`else
  assign csum_o = '0;
`endif

endmodule

// File: tb/tb_fta_copy_initiator.sv
// Self-checking bench for fta_copy_initiator: responder model plus expected request stream per copy.
module tb_fta_copy_initiator;
  import fta_bus_pkg::*;

  localparam int         CHUNK   = 16;
  localparam logic [3:0] CID     = 4'd5;
  localparam int         TIMEOUT = 1023;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic [31:0]  src_i = '0, dst_i = '0;
  logic [15:0]  len_i = '0;
  logic         busy_o, done_o, err_o, cyc_o, stb_o, we_o;
  logic [127:0] csum_o, dat_o;
  logic [2:0]   cti_o;
  logic [5:0]   blen_o;
  logic [15:0]  sel_o;
  logic [31:0]  adr_o;
  fta_tranid_t  tid_o;
  logic [3:0]   cid_o;
  logic         ack_i = 1'b0;
  logic [3:0]   cid_i = '0;
  fta_tranid_t  tid_i = '0;
  logic [127:0] dat_i = '0;

  fta_copy_initiator #(.CHUNK(CHUNK), .CID(CID), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .src_i(src_i), .dst_i(dst_i),
    .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .csum_o(csum_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .cti_o(cti_o), .blen_o(blen_o),
    .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o), .tid_o(tid_o), .cid_o(cid_o),
    .ack_i(ack_i), .cid_i(cid_i), .tid_i(tid_i), .dat_i(dat_i)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] f(input logic [31:0] a);
    return {a, ~a, a ^ 32'hA5A5_A5A5, a + 32'd7};
  endfunction

  typedef struct {logic we; logic [31:0] adr; logic [127:0] dat; int tid;} req_t;
  typedef struct {int due; logic we; logic [31:0] adr; fta_tranid_t tid; logic [3:0] cid;} pend_t;

  req_t         exp_q[$];
  pend_t        pend_q[$];
  logic [127:0] wmem [logic [31:0]];
  logic [31:0]  rd_log[$];
  int           wr_cnt = 0, done_cnt = 0, cyc_rise = 0, cycle = 0;
  int           last_rd_ack_cyc = 0, done_cyc = 0;
  logic         cyc_prev = 1'b0;
  bit           withhold_en = 0, foreign_en = 0;
  logic [31:0]  withhold_adr = '0;
  req_t         e_req;
  pend_t        p_req;

  // Responder and request checker share one view of each negedge.
  always @(negedge clk_i) begin
    cycle++;
    if (rst_i) begin
      ack_i    = 1'b0;
      cyc_prev = 1'b0;
    end else begin
      if (done_o) begin done_cnt++; done_cyc = cycle; end
      if (cyc_o && !cyc_prev) cyc_rise++;
      cyc_prev = cyc_o;
      if (stb_o) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_req: got we=%0d adr=%h expected no request", we_o, adr_o);
        end else begin
          e_req = exp_q.pop_front();
          chk("req_hdr", {we_o, cti_o, sel_o, blen_o, cyc_o, tid_o, cid_o, adr_o},
              {e_req.we, (e_req.we ? ERC : CLASSIC), 16'hFFFF, 6'd0, 1'b1, 8'(e_req.tid), CID, e_req.adr});
          if (e_req.we) chk("req_dat", dat_o, e_req.dat);
        end
        p_req.we = we_o; p_req.adr = adr_o; p_req.tid = tid_o; p_req.cid = cid_o;
        if (we_o) begin
          wmem[adr_o] = dat_o;
          wr_cnt++;
          p_req.due = cycle + 2;
          pend_q.push_back(p_req);
        end else begin
          rd_log.push_back(adr_o);
          p_req.due = cycle + 5;
          if (!(withhold_en && adr_o == withhold_adr)) pend_q.push_back(p_req);
        end
      end
      ack_i = 1'b0; cid_i = '0; tid_i = '0; dat_i = '0;
      if (pend_q.size() > 0 && pend_q[0].due <= cycle) begin
        p_req = pend_q.pop_front();
        ack_i = 1'b1; cid_i = p_req.cid; tid_i = p_req.tid;
        dat_i = p_req.we ? 128'd0 : f(p_req.adr);
        if (!p_req.we) last_rd_ack_cyc = cycle;
      end else if (foreign_en && pend_q.size() > 0 && !pend_q[0].we) begin
        ack_i = 1'b1; cid_i = 4'd2; tid_i = '0;
        dat_i = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clk_i); #1; end
  endtask

  task automatic build_exp(input logic [31:0] src, input logic [31:0] dst, input int len, input bit reads_only);
    req_t r;
    for (int base = 0; base < len; base += CHUNK) begin
      int n;
      n = (len - base < CHUNK) ? len - base : CHUNK;
      for (int k = 0; k < n; k++) begin
        r.we = 0; r.adr = src + 32'((base + k) * 16); r.dat = '0; r.tid = k;
        exp_q.push_back(r);
      end
      if (!reads_only)
        for (int k = 0; k < n; k++) begin
          r.we = 1; r.adr = dst + 32'((base + k) * 16); r.dat = f(src + 32'((base + k) * 16)); r.tid = k;
          exp_q.push_back(r);
        end
    end
  endtask

  task automatic pulse_start(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len);
    start_i = 1'b1; src_i = src; dst_i = dst; len_i = len;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    int i = 0;
    while (done_cnt == base && i < budget) begin tick(); i++; end
    chk("done_seen", 128'(done_cnt != base), 128'd1);
  endtask

  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len, input bit intrude);
    int base, bad;
    wmem.delete(); rd_log.delete(); wr_cnt = 0; cyc_rise = 0;
    build_exp(src, dst, len, 0);
    base = done_cnt;
    pulse_start(src, dst, 16'(len));
    if (intrude) begin
      tick();
      chk("err_cleared", 128'(err_o), 128'd0);
      chk("busy_during", 128'(busy_o), 128'd1);
      pulse_start(32'h0999_0000, 32'h0888_0000, 16'd5);
    end
    wait_done(base, 3000);
    tick(3);
    chk("exp_drained", 128'(exp_q.size()), 128'd0);
    chk("done_once", 128'(done_cnt - base), 128'd1);
    chk("wr_count", 128'(wr_cnt), 128'(len));
    bad = 0;
    for (int i = 0; i < len; i++) begin
      logic [31:0] da;
      da = dst + 32'(i * 16);
      if (!wmem.exists(da)) bad++;
      else if (wmem[da] !== f(src + 32'(i * 16))) bad++;
    end
    chk("dst_mem", 128'(bad), 128'd0);
    chk("idle_after", {busy_o, cyc_o, stb_o, err_o}, 4'b0000);
    exp_q.delete();
  endtask

  initial begin
    int base;
    tick(3);
    chk("rst_outs", {busy_o, done_o, err_o, stb_o, cyc_o, we_o, cti_o, blen_o, sel_o, adr_o, tid_o}, '0);
    chk("rst_dat", dat_o, '0);
    chk("rst_csum", csum_o, '0);
    chk("rst_cid", 128'(cid_o), 128'h5);
    rst_i = 1'b0;
    tick(2);

    run_copy(32'h1000, 32'h2000, 3, 0);
    chk("len3_rd0", 128'(rd_log[0]), 128'h1000);
    chk("len3_rd1", 128'(rd_log[1]), 128'h1010);
    chk("len3_rd2", 128'(rd_log[2]), 128'h1020);
    chk("len3_cyc_rises", 128'(cyc_rise), 128'd2);

    run_copy(32'h0001_0000, 32'h0002_0000, 40, 0);
    chk("len40_cyc_rises", 128'(cyc_rise), 128'd6);
    chk("len40_reads", 128'(rd_log.size()), 128'd40);

    foreign_en = 1;
    run_copy(32'h3000, 32'h4000, 5, 0);
    foreign_en = 0;

    // read at 0x5020 never acked
    wmem.delete(); rd_log.delete(); wr_cnt = 0;
    withhold_en = 1; withhold_adr = 32'h5020;
    build_exp(32'h5000, 32'h6000, 3, 1);
    base = done_cnt;
    pulse_start(32'h5000, 32'h6000, 16'd3);
    wait_done(base, TIMEOUT + 200);
    chk("tmo_err", 128'(err_o), 128'd1);
    chk("tmo_bus_idle", {cyc_o, stb_o, busy_o}, 3'b000);
    chk("tmo_window", 128'((done_cyc - last_rd_ack_cyc) >= TIMEOUT &&
                           (done_cyc - last_rd_ack_cyc) <= TIMEOUT + 4), 128'd1);
    chk("tmo_no_writes", 128'(wr_cnt), 128'd0);
    tick(3);
    chk("tmo_err_sticky", 128'(err_o), 128'd1);
    chk("tmo_done_once", 128'(done_cnt - base), 128'd1);
    exp_q.delete();
    withhold_en = 0;

    run_copy(32'h6000, 32'h7000, 3, 1);

    rd_log.delete();
    base = done_cnt;
    pulse_start(32'h8000, 32'h9000, 16'd0);
    chk("len0_done", {done_o, busy_o}, 2'b10);
    tick();
    chk("len0_done_low", 128'(done_o), 128'd0);
    tick(5);
    chk("len0_no_bus", 128'(rd_log.size()), 128'd0);
    chk("len0_done_once", 128'(done_cnt - base), 128'd1);

    run_copy(32'hFFFF_FFF0, 32'h0000_8000, 2, 0);
    chk("wrap_rd0", 128'(rd_log[0]), 128'hFFFF_FFF0);
    chk("wrap_rd1", 128'(rd_log[1]), 128'h0);

    run_copy(32'h0000_A000, 32'h0000_B000, 2, 0);
`ifdef FTA_COPY_CSUM_EN
    chk("csum_ab", csum_o, f(32'h0000_A000) ^ f(32'h0000_A010));
`else
    chk("csum_off", csum_o, '0);
`endif

    rd_log.delete();
    build_exp(32'h0000_C000, 32'h0000_D000, 20, 0);
    base = done_cnt;
    pulse_start(32'h0000_C000, 32'h0000_D000, 16'd20);
    for (int i = 0; i < 50 && rd_log.size() < 2; i++) tick();
    chk("midrd_started", 128'(rd_log.size() >= 2), 128'd1);
    rst_i = 1'b1;
    #1;
    chk("midrd_rst_outs", {busy_o, done_o, err_o, stb_o, cyc_o, we_o, cti_o, sel_o, adr_o, tid_o}, '0);
    chk("midrd_rst_cid", 128'(cid_o), 128'h5);
    exp_q.delete();
    tick(2);
    rst_i = 1'b0;
    tick(20);
    chk("midrd_no_done", 128'(done_cnt - base), 128'd0);
    chk("midrd_idle", {busy_o, cyc_o}, 2'b00);
    run_copy(32'h0000_E000, 32'h0000_F000, 3, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
